// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side bus of the UART transmit arbiter.
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int PACKET_SIZE = 16
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*PACKET_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]             ack;
  logic [PACKET_SIZE-1:0]         tx_data;
  logic                           tx_send;
  logic                           busy;
  logic [$clog2(NUM_REQ)-1:0]     grant_id;

  modport master (
    output req, req_data,
    input  ack, tx_data, tx_send, busy, grant_id
  );

  modport slave (
    input  req, req_data,
    output ack, tx_data, tx_send, busy, grant_id
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Shares one UART transmitter among NUM_REQ requesters and times
//            each frame locally. Define UART_ARB_FIXED_PRIO_EN for fixed
//            priority (lowest index wins) instead of round-robin.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PACKET_SIZE = 16,
  parameter int CYCLE_DIV   = 100,
  parameter int PROP_DELAY  = 2,
  parameter int GAP_BITS    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int FRAME_CYCLES = (PACKET_SIZE + PROP_DELAY + GAP_BITS) * CYCLE_DIV;
  localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);
  localparam int ID_W         = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_ACK  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [CNT_W-1:0]       r_cnt;
  logic [ID_W-1:0]        r_winner;
  logic [ID_W-1:0]        r_grantId;
  logic [PACKET_SIZE-1:0] r_txData;
  logic                   r_txSend;
  logic                   r_busy;
  logic [NUM_REQ-1:0]     r_ack;
  logic                   w_found;
  logic [ID_W-1:0]        w_winner;
  logic [ID_W-1:0]        w_idx;
`ifndef UART_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]        r_rrPtr;
`endif

  // Scan starts at the priority pointer; first asserted request wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      w_idx = ID_W'(i);
`else
      w_idx = ID_W'((int'(r_rrPtr) + i) % NUM_REQ);
`endif
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // r_cnt counts from SEND entry, so the frame length is independent of the SEND/WAIT split.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_stateNext = S_LOAD;
      S_LOAD:  w_stateNext = S_SEND;
      S_SEND:  if (r_cnt == CNT_W'(CYCLE_DIV - 1)) w_stateNext = S_WAIT;
      S_WAIT:  if (r_cnt == CNT_W'(FRAME_CYCLES - 1)) w_stateNext = S_ACK;
      S_ACK:   w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so each lags its state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_winner  <= '0;
      r_grantId <= '0;
      r_txData  <= '0;
      r_txSend  <= 1'b0;
      r_busy    <= 1'b0;
      r_ack     <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      r_rrPtr   <= '0;
`endif
    end else begin
      r_txSend <= (r_state == S_SEND);
      r_busy   <= (r_state != S_IDLE);
      r_ack    <= '0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_found) r_winner <= w_winner;
        end
        S_LOAD: begin
          r_txData  <= bus.req_data[int'(r_winner)*PACKET_SIZE +: PACKET_SIZE];
          r_grantId <= r_winner;
        end
        S_SEND, S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_ACK: begin
          r_cnt            <= '0;
          r_ack[r_grantId] <= 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
          r_rrPtr <= (r_grantId == ID_W'(NUM_REQ - 1)) ? '0 : r_grantId + ID_W'(1);
`endif
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.tx_data  = r_txData;
  assign bus.tx_send  = r_txSend;
  assign bus.busy     = r_busy;
  assign bus.grant_id = r_grantId;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter against a round-robin
//            reference model (NUM_REQ=4, PACKET_SIZE=16, CYCLE_DIV=4).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   rrPtr = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4), .PACKET_SIZE(16)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(4), .PACKET_SIZE(16), .CYCLE_DIV(4), .PROP_DELAY(2), .GAP_BITS(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelPick(input logic [3:0] r);
    int j;
    for (int i = 0; i < 4; i++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      j = i;
`else
      j = (rrPtr + i) % 4;
`endif
      if (r[j[1:0]]) return j;
    end
    return -1;
  endfunction

  // Runs one frame from the request currently on the bus. expLat is the number
  // of negedges until tx_send is seen high; keepMask is applied to req on ack.
  task automatic runFrame(input int expLat, input logic [3:0] keepMask, input int pokeN,
                          input logic [3:0] pokeReq, input logic [15:0] pokeWord,
                          input int pokeIdx);
    int          expWin, t, n, hi;
    logic [15:0] expWord;
    logic [3:0]  expAck;
    logic [63:0] d;
    expWin = modelPick(bus.req);
    if (expWin < 0) expWin = 0;
    d       = bus.req_data;
    expWord = d[expWin*16 +: 16];
    expAck  = 4'b0001 << expWin;
    t = 0;
    while (bus.tx_send !== 1'b1 && t < 8) begin
      @(negedge clk);
      t++;
      if (t == expLat - 1) begin
        chk("busy_load", {63'd0, bus.busy}, 64'd1);
        chk("grant_id", {62'd0, bus.grant_id}, 64'(expWin));
        chk("tx_data_load", {48'd0, bus.tx_data}, {48'd0, expWord});
      end
    end
    chk("send_latency", 64'(t), 64'(expLat));
    hi = 1;
    n  = 0;
    while (bus.ack === 4'b0000 && n < 120) begin
      @(negedge clk);
      n++;
      if (n == pokeN) begin
        bus.req = pokeReq;
        if (pokeIdx >= 0) bus.req_data[pokeIdx*16 +: 16] = pokeWord;
      end
      if (bus.tx_send === 1'b1) hi++;
    end
    chk("send_len", 64'(hi), 64'd4);
    chk("ack_latency", 64'(n), 64'd80);
    chk("ack_vec", {60'd0, bus.ack}, {60'd0, expAck});
    bus.req = bus.req & keepMask;
    @(negedge clk);
    chk("ack_pulse", {60'd0, bus.ack}, 64'd0);
    chk("busy_after", {63'd0, bus.busy}, 64'd0);
    chk("tx_data_hold", {48'd0, bus.tx_data}, {48'd0, expWord});
`ifndef UART_ARB_FIXED_PRIO_EN
    rrPtr = (expWin + 1) % 4;
`endif
  endtask

  initial begin
    int   t;
    logic ackSeen;
    bus.req      = 4'b0000;
    bus.req_data = {$urandom, $urandom};
    rst_n        = 1'b0;
    #1;
    chk("rst_tx_send", {63'd0, bus.tx_send}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_ack", {60'd0, bus.ack}, 64'd0);
    chk("rst_tx_data", {48'd0, bus.tx_data}, 64'd0);
    chk("rst_grant", {62'd0, bus.grant_id}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", {63'd0, bus.busy}, 64'd0);
    chk("idle_send", {63'd0, bus.tx_send}, 64'd0);

    // All requesters held: grants rotate 0,1,2,3,0.
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++)
      runFrame((i == 0) ? 3 : 2, (i == 4) ? 4'b0000 : 4'b1111, -1, 4'b0, 16'h0, -1);
    repeat (2) @(negedge clk);

    // Single requester 0.
    bus.req_data[15:0] = 16'hA5C3;
    bus.req = 4'b0001;
    runFrame(3, 4'b0000, -1, 4'b0, 16'h0, -1);
    repeat (3) @(negedge clk);

    // Word changes during SEND must not reach tx_data.
    bus.req_data[31:16] = 16'h1234;
    bus.req = 4'b0010;
    runFrame(3, 4'b0000, 2, 4'b0010, 16'hFFFF, 1);
    repeat (2) @(negedge clk);

    // Reset in the middle of SEND.
    bus.req = 4'b0010;
    t = 0;
    while (bus.tx_send !== 1'b1 && t < 8) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_send", {63'd0, bus.tx_send}, 64'd0);
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_data", {48'd0, bus.tx_data}, 64'd0);
    chk("midrst_grant", {62'd0, bus.grant_id}, 64'd0);
    rrPtr   = 0;
    bus.req = 4'b1010;
    ackSeen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack !== 4'b0000) ackSeen = 1'b1;
    end
    chk("midrst_no_ack", {63'd0, ackSeen}, 64'd0);
    rst_n = 1'b1;
    runFrame(3, 4'b0000, -1, 4'b0, 16'h0, -1);
    repeat (2) @(negedge clk);

    // Requester 2 drops during WAIT; pending requester 3 follows.
    bus.req = 4'b1100;
    runFrame(3, 4'b1000, 20, 4'b1000, 16'h0, -1);
    runFrame(2, 4'b0000, -1, 4'b0, 16'h0, -1);

    // Random requests and words.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      bus.req_data = {$urandom, $urandom};
      bus.req      = 4'($urandom_range(1, 15));
      runFrame(3, 4'b0000, -1, 4'b0, 16'h0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
